sram_responder: RTL and testbench

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/sram_resp_pkg.sv | 12 +
 rtl/sram_resp_port.sv | 48 ++++
 rtl/sram_responder.sv | 94 +++++++++
 tb/tb_sram_responder.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_resp_pkg.sv
// Shared definitions for the SRAM responder: per-port FSM state encoding and wait-counter width.
package sram_resp_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/sram_resp_port.sv
// One request/response port: IDLE -> WAIT (optional) -> RESP handshake with a fixed wait count.
module sram_resp_port
    import sram_resp_pkg::*;
#(
    parameter int WAIT_CYC = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic accept,
    output logic load,
    output logic data_ok
);
    localparam bit               NO_WAIT  = (WAIT_CYC == 0);
    localparam logic [CNT_W-1:0] CNT_LOAD = NO_WAIT ? '0 : CNT_W'(WAIT_CYC - 1);

    state_e           state;
    logic [CNT_W-1:0] cnt;

    // load marks the edge on which the response data must be presented.
    assign accept  = (state == ST_IDLE) && en && !rst;
    assign load    = NO_WAIT ? accept : ((state == ST_WAIT) && (cnt == '0) && !rst);
    assign data_ok = (state == ST_RESP) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        if (NO_WAIT) state <= ST_RESP;
                        else         state <= ST_WAIT;
                        cnt <= CNT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) state <= ST_RESP;
                    else           cnt   <= cnt - 1'b1;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sram_responder.sv
// SRAM responder: 64-bit instruction fetch port and 32-bit byte-writable data port sharing
// one word array, each port with an independent fixed-latency handshake.
module sram_responder
    import sram_resp_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int INST_WAIT = 0,
    parameter int DATA_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [31:0] inst_sram_addr,
    output logic [63:0] inst_sram_rdata,
    output logic        inst_data_ok,
    output logic        inst_data_ok1,
    output logic        inst_data_ok2,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_data_ok
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] inst_idx, inst_idx_hi, data_idx;
    logic              inst_top;
    logic [64:0]       inst_word, inst_hold;
    logic [31:0]       data_word, data_hold;
    logic              inst_accept, inst_load, data_accept, data_load;
    logic              inst_top_q;
    logic              unused_addr_bits;

    assign inst_idx    = inst_sram_addr[ADDR_W+1:2];
    assign data_idx    = data_sram_addr[ADDR_W+1:2];
    assign inst_idx_hi = inst_idx + 1'b1;
    assign inst_top    = &inst_idx;

    // Fetch word carries the top-of-memory flag in bit 64 so ok2 travels with the data.
    assign inst_word = {inst_top, (inst_top ? 32'h0 : mem[inst_idx_hi]), mem[inst_idx]};
    assign data_word = (data_sram_wen != 4'h0) ? 32'h0 : mem[data_idx];

    assign unused_addr_bits = ^{inst_sram_addr[31:ADDR_W+2], inst_sram_addr[1:0],
                                data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    sram_resp_port #(.WAIT_CYC(INST_WAIT)) u_inst_port (
        .clk     (clk),
        .rst     (rst),
        .en      (inst_sram_en),
        .accept  (inst_accept),
        .load    (inst_load),
        .data_ok (inst_data_ok)
    );

    sram_resp_port #(.WAIT_CYC(DATA_WAIT)) u_data_port (
        .clk     (clk),
        .rst     (rst),
        .en      (data_sram_en),
        .accept  (data_accept),
        .load    (data_load),
        .data_ok (data_data_ok)
    );

    // NOTE: the array has no reset so it maps to plain RAM; contents survive rst.
    always_ff @(posedge clk) begin
        if (data_accept) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wen[b]) mem[data_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
            end
        end
    end

    // NOTE: non-blocking updates mean a read sampled on the write edge still sees the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_hold       <= '0;
            inst_top_q      <= 1'b0;
            inst_sram_rdata <= '0;
            data_hold       <= '0;
            data_sram_rdata <= '0;
        end else begin
            if (inst_accept) inst_hold <= inst_word;
            if (inst_load)   {inst_top_q, inst_sram_rdata} <= (INST_WAIT == 0) ? inst_word : inst_hold;
            if (data_accept) data_hold <= data_word;
            if (data_load)   data_sram_rdata <= (DATA_WAIT == 0) ? data_word : data_hold;
        end
    end

    assign inst_data_ok1 = inst_data_ok;
    assign inst_data_ok2 = inst_data_ok & ~inst_top_q;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench: two responder instances (no waits / with waits) against a word-array model.
module tb_sram_responder;
    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;
    localparam int IW_A  = 0;
    localparam int DW_A  = 0;
    localparam int IW_B  = 2;
    localparam int DW_B  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]       inst_en, inst_ok, inst_ok1, inst_ok2;
    logic [1:0][31:0] inst_addr;
    logic [1:0][63:0] inst_rdata;
    logic [1:0]       data_en, data_ok;
    logic [1:0][3:0]  data_wen;
    logic [1:0][31:0] data_addr, data_wdata, data_rdata;

    logic [31:0] mdl [2][DEPTH];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_responder #(.ADDR_W(AW), .INST_WAIT(IW_A), .DATA_WAIT(DW_A)) dut_a (
        .clk(clk), .rst(rst),
        .inst_sram_en(inst_en[0]), .inst_sram_addr(inst_addr[0]), .inst_sram_rdata(inst_rdata[0]),
        .inst_data_ok(inst_ok[0]), .inst_data_ok1(inst_ok1[0]), .inst_data_ok2(inst_ok2[0]),
        .data_sram_en(data_en[0]), .data_sram_wen(data_wen[0]), .data_sram_addr(data_addr[0]),
        .data_sram_wdata(data_wdata[0]), .data_sram_rdata(data_rdata[0]), .data_data_ok(data_ok[0])
    );

    sram_responder #(.ADDR_W(AW), .INST_WAIT(IW_B), .DATA_WAIT(DW_B)) dut_b (
        .clk(clk), .rst(rst),
        .inst_sram_en(inst_en[1]), .inst_sram_addr(inst_addr[1]), .inst_sram_rdata(inst_rdata[1]),
        .inst_data_ok(inst_ok[1]), .inst_data_ok1(inst_ok1[1]), .inst_data_ok2(inst_ok2[1]),
        .data_sram_en(data_en[1]), .data_sram_wen(data_wen[1]), .data_sram_addr(data_addr[1]),
        .data_sram_wdata(data_wdata[1]), .data_sram_rdata(data_rdata[1]), .data_data_ok(data_ok[1])
    );

    function automatic int dwait(input int u);
        return (u == 0) ? DW_A : DW_B;
    endfunction

    function automatic int iwait(input int u);
        return (u == 0) ? IW_A : IW_B;
    endfunction

    // Byte address for word n with random alias bits above and below the index.
    function automatic logic [31:0] mk_addr(input int n);
        logic [31:0] a;
        logic [31:0] nn;
        a  = $urandom();
        nn = n;
        a[AW+1:2] = nn[AW-1:0];
        return a;
    endfunction

    function automatic logic [31:0] exp_read(input int u, input int n);
        return mdl[u][n];
    endfunction

    function automatic logic [63:0] exp_fetch(input int u, input int n);
        if (n == DEPTH - 1) return {32'h0, mdl[u][n]};
        return {mdl[u][n + 1], mdl[u][n]};
    endfunction

    task automatic mdl_write(input int u, input int n, input logic [3:0] wen, input logic [31:0] wd);
        for (int b = 0; b < 4; b++)
            if (wen[b]) mdl[u][n][8*b +: 8] = wd[8*b +: 8];
    endtask

    task automatic data_xfer(input int u, input logic [3:0] wen, input logic [31:0] addr,
                             input logic [31:0] wd, output logic [31:0] rd, output int lat,
                             output logic after);
        @(negedge clk);
        data_en[u] = 1'b1; data_wen[u] = wen; data_addr[u] = addr; data_wdata[u] = wd;
        lat = -1; rd = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (data_ok[u]) begin lat = i; rd = data_rdata[u]; break; end
        end
        data_en[u] = 1'b0;
        @(posedge clk); #1;
        after = data_ok[u];
    endtask

    task automatic fetch_xfer(input int u, input logic [31:0] addr, output logic [63:0] rd,
                              output int lat, output logic ok1, output logic ok2, output logic after);
        @(negedge clk);
        inst_en[u] = 1'b1; inst_addr[u] = addr;
        lat = -1; rd = '0; ok1 = 1'b0; ok2 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (inst_ok[u]) begin lat = i; rd = inst_rdata[u]; ok1 = inst_ok1[u]; ok2 = inst_ok2[u]; break; end
        end
        inst_en[u] = 1'b0;
        @(posedge clk); #1;
        after = inst_ok[u];
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            n_vec++;
            if ({inst_ok[u], inst_ok1[u], inst_ok2[u], data_ok[u], inst_rdata[u], data_rdata[u]} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs dut%0d: ok=%b%b%b%b inst_rdata=%h data_rdata=%h want all 0",
                         u, inst_ok[u], inst_ok1[u], inst_ok2[u], data_ok[u], inst_rdata[u], data_rdata[u]);
            end
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_preload;
        logic [31:0] rd, wd;
        int lat, bad;
        logic after;
        for (int u = 0; u < 2; u++) begin
            bad = 0;
            for (int k = 0; k < 66; k++) begin
                int n;
                n  = (k < 64) ? k : DEPTH - 130 + k;
                wd = $urandom() | 32'h1;
                data_xfer(u, 4'hF, mk_addr(n), wd, rd, lat, after);
                mdl_write(u, n, 4'hF, wd);
                if (lat != dwait(u) || rd !== 32'h0 || after !== 1'b0) bad++;
            end
            n_vec++;
            if (bad != 0) begin n_err++; $display("FAIL preload_writes dut%0d: %0d bad responses, want 0", u, bad); end
        end
    endtask

    task automatic test_fetch_basic;
        logic [63:0] rd;
        logic [31:0] drd;
        int lat;
        logic ok1, ok2, after;
        for (int u = 0; u < 2; u++) begin
            data_xfer(u, 4'hF, 32'h0000_0010, 32'h1111_1111, drd, lat, after);
            data_xfer(u, 4'hF, 32'h0000_0014, 32'h2222_2222, drd, lat, after);
            mdl_write(u, 4, 4'hF, 32'h1111_1111);
            mdl_write(u, 5, 4'hF, 32'h2222_2222);
            fetch_xfer(u, 32'h0000_0010, rd, lat, ok1, ok2, after);
            n_vec++;
            if (rd !== 64'h2222_2222_1111_1111) begin n_err++; $display("FAIL fetch_basic_data dut%0d: got %h want 2222222211111111", u, rd); end
            n_vec++;
            if (lat != iwait(u) || {ok1, ok2, after} !== 3'b110) begin
                n_err++; $display("FAIL fetch_basic_strobe dut%0d: lat=%0d ok1/ok2/after=%b want lat=%0d 110", u, lat, {ok1, ok2, after}, iwait(u));
            end
            repeat (3) @(posedge clk);
            #1;
            n_vec++;
            if (inst_rdata[u] !== 64'h2222_2222_1111_1111) begin n_err++; $display("FAIL fetch_hold dut%0d: got %h want 2222222211111111", u, inst_rdata[u]); end
        end
    endtask

    task automatic test_fetch_top;
        logic [63:0] rd;
        int lat;
        logic ok1, ok2, after;
        logic [31:0] addrs [2];
        addrs[0] = 32'h0000_3FFC;
        addrs[1] = 32'hFFFF_FFFF;
        for (int k = 0; k < 2; k++) begin
            fetch_xfer(0, addrs[k], rd, lat, ok1, ok2, after);
            n_vec++;
            if (rd !== {32'h0, mdl[0][DEPTH-1]} || ok1 !== 1'b1 || ok2 !== 1'b0) begin
                n_err++; $display("FAIL fetch_top addr=%h: rdata=%h ok1=%b ok2=%b want %h 1 0", addrs[k], rd, ok1, ok2, {32'h0, mdl[0][DEPTH-1]});
            end
        end
    endtask

    task automatic test_byte_write;
        logic [31:0] rd;
        int lat;
        logic after;
        data_xfer(0, 4'hF, 32'h0000_0100, 32'h0000_0000, rd, lat, after);
        data_xfer(0, 4'b0101, 32'h0000_0100, 32'hAABB_CCDD, rd, lat, after);
        n_vec++;
        if (lat != 0 || rd !== 32'h0) begin n_err++; $display("FAIL byte_write_resp: lat=%0d rdata=%h want 0 00000000", lat, rd); end
        data_xfer(0, 4'h0, 32'h0000_0100, 32'hFFFF_FFFF, rd, lat, after);
        n_vec++;
        if (lat != 0 || rd !== 32'h00BB_00DD) begin n_err++; $display("FAIL byte_write_read: lat=%0d rdata=%h want 0 00bb00dd", lat, rd); end
        mdl[0][64] = 32'h00BB_00DD;
    endtask

    task automatic test_same_cycle;
        logic [31:0] old_w;
        logic [63:0] rd;
        int lat;
        logic ok1, ok2, after;
        old_w = mdl[0][8];
        @(negedge clk);
        data_en[0] = 1'b1; data_wen[0] = 4'hF; data_addr[0] = 32'h20; data_wdata[0] = 32'hDEAD_BEEF;
        inst_en[0] = 1'b1; inst_addr[0] = 32'h20;
        @(posedge clk); #1;
        n_vec++;
        if (inst_ok[0] !== 1'b1 || data_ok[0] !== 1'b1 || inst_rdata[0][31:0] !== old_w) begin
            n_err++; $display("FAIL same_cycle: inst_ok=%b data_ok=%b low=%h want 1 1 %h", inst_ok[0], data_ok[0], inst_rdata[0][31:0], old_w);
        end
        data_en[0] = 1'b0; inst_en[0] = 1'b0;
        @(posedge clk);
        mdl_write(0, 8, 4'hF, 32'hDEAD_BEEF);
        fetch_xfer(0, 32'h20, rd, lat, ok1, ok2, after);
        n_vec++;
        if (rd[31:0] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL same_cycle_refetch: low=%h want deadbeef", rd[31:0]); end
    endtask

    task automatic test_random;
        logic [31:0] rd, wd;
        logic [63:0] frd;
        logic [3:0] wen;
        logic ok1, ok2, after;
        int lat;
        for (int k = 0; k < 300; k++) begin
            int u, op, n;
            u  = $urandom_range(1, 0);
            op = $urandom_range(2, 0);
            if (op == 0) begin
                n = ($urandom_range(7, 0) == 0) ? DEPTH - 1 - $urandom_range(1, 0) : $urandom_range(62, 0);
                fetch_xfer(u, mk_addr(n), frd, lat, ok1, ok2, after);
                n_vec++;
                if (lat != iwait(u) || frd !== exp_fetch(u, n) || ok1 !== 1'b1 || ok2 !== (n != DEPTH - 1) || after !== 1'b0) begin
                    n_err++; $display("FAIL rand_fetch dut%0d idx=%0d: lat=%0d rdata=%h ok1=%b ok2=%b after=%b want lat=%0d rdata=%h",
                                      u, n, lat, frd, ok1, ok2, after, iwait(u), exp_fetch(u, n));
                end
            end else begin
                n   = $urandom_range(63, 0);
                wen = (op == 1) ? 4'h0 : 4'($urandom_range(15, 1));
                wd  = $urandom();
                data_xfer(u, wen, mk_addr(n), wd, rd, lat, after);
                n_vec++;
                if (lat != dwait(u) || rd !== ((wen == 4'h0) ? exp_read(u, n) : 32'h0) || after !== 1'b0) begin
                    n_err++; $display("FAIL rand_data dut%0d idx=%0d wen=%h: lat=%0d rdata=%h after=%b want lat=%0d rdata=%h",
                                      u, n, wen, lat, rd, after, dwait(u), (wen == 4'h0) ? exp_read(u, n) : 32'h0);
                end
                mdl_write(u, n, wen, wd);
            end
        end
    endtask

    // Held en: responses every WAIT+2 cycles, at cycle offsets WAIT and 2*WAIT+2.
    task automatic test_back_to_back;
        for (int u = 0; u < 2; u++) begin
            int w, n;
            logic exp_ok;
            w = dwait(u);
            n = $urandom_range(63, 0);
            @(negedge clk);
            data_en[u] = 1'b1; data_wen[u] = 4'h0; data_addr[u] = mk_addr(n);
            for (int i = 0; i < 2 * (w + 2); i++) begin
                @(posedge clk); #1;
                exp_ok = (i == w) || (i == 2 * w + 2);
                n_vec++;
                if (data_ok[u] !== exp_ok || (exp_ok && data_rdata[u] !== mdl[u][n])) begin
                    n_err++; $display("FAIL b2b_data dut%0d cyc=%0d: ok=%b rdata=%h want ok=%b rdata=%h", u, i, data_ok[u], data_rdata[u], exp_ok, mdl[u][n]);
                end
            end
            data_en[u] = 1'b0;
            w = iwait(u);
            @(negedge clk);
            inst_en[u] = 1'b1; inst_addr[u] = mk_addr(n);
            for (int i = 0; i < 2 * (w + 2); i++) begin
                @(posedge clk); #1;
                exp_ok = (i == w) || (i == 2 * w + 2);
                n_vec++;
                if (inst_ok[u] !== exp_ok) begin
                    n_err++; $display("FAIL b2b_inst dut%0d cyc=%0d: ok=%b want %b", u, i, inst_ok[u], exp_ok);
                end
            end
            inst_en[u] = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic test_reset_cancel;
        logic [31:0] rd, v;
        logic [63:0] frd;
        logic ok1, ok2, after, seen;
        int lat, n;
        n = $urandom_range(63, 0);
        v = $urandom() | 32'h8000_0000;
        data_xfer(1, 4'h0, mk_addr(10), 32'h0, rd, lat, after);
        fetch_xfer(1, mk_addr(10), frd, lat, ok1, ok2, after);
        @(negedge clk);
        data_en[1] = 1'b1; data_wen[1] = 4'hF; data_addr[1] = mk_addr(n); data_wdata[1] = v;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        data_wen[1] = 4'h0;
        seen = 1'b0;
        @(posedge clk); #1;
        seen = data_ok[1];
        n_vec++;
        if (data_ok[1] !== 1'b0 || data_rdata[1] !== 32'h0 || inst_rdata[1] !== 64'h0) begin
            n_err++; $display("FAIL rst_cancel_outputs: ok=%b data_rdata=%h inst_rdata=%h want 0", data_ok[1], data_rdata[1], inst_rdata[1]);
        end
        @(posedge clk); #1;
        seen = seen | data_ok[1];
        @(negedge clk) rst = 1'b0;
        mdl_write(1, n, 4'hF, v);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (data_ok[1]) begin lat = i; rd = data_rdata[1]; break; end
        end
        data_en[1] = 1'b0;
        @(posedge clk);
        n_vec++;
        if (seen !== 1'b0 || lat != DW_B) begin
            n_err++; $display("FAIL rst_cancel_timing: ok_in_reset=%b lat=%0d want 0 %0d", seen, lat, DW_B);
        end
        n_vec++;
        if (rd !== v) begin n_err++; $display("FAIL rst_write_persists: rdata=%h want %h", rd, v); end
    endtask

    initial begin
        inst_en = '0; inst_addr = '0; data_en = '0; data_wen = '0; data_addr = '0; data_wdata = '0;
        for (int u = 0; u < 2; u++)
            for (int n = 0; n < DEPTH; n++) mdl[u][n] = 32'h0;
        test_reset();
        test_preload();
        test_fetch_basic();
        test_fetch_top();
        test_byte_write();
        test_same_cycle();
        test_random();
        test_back_to_back();
        test_reset_cancel();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
